// File: rtl/mac_mdc_engine_if.sv
// Valid/ready stream bundle shared by the MAC datapath engine and its streamer.
// The source drives valid/data/strb and samples ready; the sink does the reverse.
interface mac_mdc_engine_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                      valid;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     data;
  logic [DATA_WIDTH/8-1:0]   strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/mac_mdc_engine.sv
// MAC datapath engine: joins the a/b/c streams, multiplies in stage 1 and
// shifts/accumulates/adds in stage 2, producing the d stream. Supports an
// element-wise mode and an accumulate mode that emits one result per job.
module mac_mdc_engine #(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned SHIFT_WIDTH = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   clear_i,
  mac_mdc_engine_if.sink         a,
  mac_mdc_engine_if.sink         b,
  mac_mdc_engine_if.sink         c,
  mac_mdc_engine_if.source       d,
  input  logic                   start_i,
  input  logic [CNT_WIDTH-1:0]   len_i,
  input  logic                   mode_i,
  input  logic [SHIFT_WIDTH-1:0] shift_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CNT_WIDTH-1:0]   cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   len_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   mode_q;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic                   done_q;

  // Stage 1: registered product, addend and end-of-job marker.
  logic                   s1_valid_q;
  logic                   s1_last_q;
  logic signed [63:0]     s1_p_q;
  logic [31:0]            s1_c_q;

  // Stage 2: accumulator and the output register behind d.
  logic signed [63:0]     acc_q;
  logic                   d_valid_q;
  logic                   d_last_q;
  logic [31:0]            d_data_q;

  logic                   is_last;
  logic                   need_c;
  logic                   fire;
  logic                   s1_free;
  logic                   s2_take;
  logic                   d_hs;
  logic                   start_job;
  logic                   start_empty;
  logic                   done_set;
  logic                   s2_emit;
  logic signed [63:0]     product;
  logic signed [63:0]     s2_sum;
  logic signed [63:0]     s2_operand;
  logic signed [63:0]     s2_shifted;
  logic [3:0]             unused_strb;

  // Element bookkeeping and the input join.
  assign is_last   = (cnt_q == len_q - 1'b1);
  assign need_c    = !mode_q || is_last;
  assign s2_take   = s1_valid_q && (!d_valid_q || d.ready) && enable_i;
  assign s1_free   = !s1_valid_q || s2_take;
  assign fire      = (state_q == RUN) && enable_i && s1_free &&
                     a.valid && b.valid && (c.valid || !need_c);
  assign a.ready   = fire;
  assign b.ready   = fire;
  assign c.ready   = fire && need_c;

  // Output handshake is blocked while disabled, so the sink cannot pop a
  // result the engine is not going to retire.
  assign d_hs      = d_valid_q && d.ready && enable_i;
  assign d.valid   = d_valid_q && enable_i;
  assign d.data    = d_data_q;
  assign d.strb    = 4'hF;

  assign start_job   = (state_q == IDLE) && start_i && enable_i && (len_i != '0);
  assign start_empty = (state_q == IDLE) && start_i && enable_i && (len_i == '0);
  assign done_set    = start_empty || ((state_q == DRAIN) && d_hs && d_last_q);

  // Datapath arithmetic: full 64-bit signed product, optional accumulation,
  // arithmetic shift, then 32-bit truncation before the addend.
  assign product    = 64'($signed(a.data)) * 64'($signed(b.data));
  assign s2_sum     = acc_q + s1_p_q;
  assign s2_operand = mode_q ? s2_sum : s1_p_q;
  assign s2_shifted = s2_operand >>> shift_q;
  assign s2_emit    = !mode_q || s1_last_q;

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign cnt_o  = cnt_q;

  // Byte strobes on the inputs carry no information for this datapath.
  assign unused_strb = a.strb ^ b.strb ^ c.strb;

  // Next-state logic for the job FSM.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_job)            state_d = RUN;
      RUN:     if (fire && is_last)      state_d = DRAIN;
      DRAIN:   if (d_hs && d_last_q)     state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Job control: state, latched job parameters, element counter, done pulse.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else if (clear_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_set;
      if (start_job) begin
        len_q   <= len_i;
        mode_q  <= mode_i;
        shift_q <= shift_i;
        cnt_q   <= '0;
      end else if (fire) begin
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

  // Stage 1: capture the joined operands on fire, release on stage-2 take.
  // NOTE: datapath registers are reset too, since the reset value of the
  // observable result is defined; pure-payload regs could otherwise skip it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_p_q     <= '0;
      s1_c_q     <= '0;
    end else if (clear_i) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_p_q     <= '0;
      s1_c_q     <= '0;
    end else if (fire) begin
      s1_valid_q <= 1'b1;
      s1_last_q  <= is_last;
      s1_p_q     <= product;
      s1_c_q     <= need_c ? c.data : 32'd0;
    end else if (s2_take) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2: accumulate or emit a result; hold d until it is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      d_valid_q <= 1'b0;
      d_last_q  <= 1'b0;
      d_data_q  <= '0;
    end else if (clear_i) begin
      acc_q     <= '0;
      d_valid_q <= 1'b0;
      d_last_q  <= 1'b0;
      d_data_q  <= '0;
    end else if (start_job) begin
      acc_q     <= '0;
    end else if (s2_take) begin
      if (mode_q) begin
        acc_q <= s1_last_q ? 64'sd0 : s2_sum;
      end
      if (s2_emit) begin
        d_valid_q <= 1'b1;
        d_last_q  <= s1_last_q;
        d_data_q  <= s2_shifted[31:0] + s1_c_q;
      end else if (d_hs) begin
        d_valid_q <= 1'b0;
      end
    end else if (d_hs) begin
      d_valid_q <= 1'b0;
    end
  end

endmodule

// File: doc/mac_mdc_engine.md
Name: mac_mdc_engine

Overview:
- Datapath engine directly downstream of the MAC streamer.
- Consumes the a, b and c 32-bit streams and produces the d stream, which feeds the streamer's sink.
- Two modes:
  - Element-wise: d[i] = (a[i]*b[i] >>> shift) + c[i].
  - Accumulate: d = (sum(a[i]*b[i]) >>> shift) + c, with c consumed once, on the last element.
- Two-stage pipeline with full valid/ready backpressure; the controller drives it through a start/len/mode/shift job interface.

Parameters:
- CNT_WIDTH, 16, width of the job length and element counter.
- SHIFT_WIDTH, 6, width of the right-shift amount.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  local enable; low freezes all state and blocks all handshakes.
- clear_i  in  1  synchronous clear; returns all state to reset values.
- a  hwpe_stream_intf_stream.sink  32  operand A stream.
- b  hwpe_stream_intf_stream.sink  32  operand B stream.
- c  hwpe_stream_intf_stream.sink  32  addend stream.
- d  hwpe_stream_intf_stream.source  32  result stream; strb always 4'hF.
- start_i  in  1  single-cycle job start.
- len_i  in  CNT_WIDTH  number of a/b elements in the job; sampled on start.
- mode_i  in  1  0 = element-wise, 1 = accumulate; sampled on start.
- shift_i  in  SHIFT_WIDTH  arithmetic right-shift amount; sampled on start.
- busy_o  out  1  job in progress.
- done_o  out  1  single-cycle pulse at job end.
- cnt_o  out  CNT_WIDTH  a/b elements consumed in the current job.

Behaviour:
- Reset / clear values: busy_o=0, done_o=0, cnt_o=0, d.valid=0, d.data=0, all sink ready=0, accumulator=0, FSM in IDLE.
- States: IDLE, RUN, DRAIN.
  - IDLE→RUN: start_i & enable_i & len_i≠0. len, mode and shift are latched, the counter and accumulator are zeroed, and busy_o goes to 1 on the next cycle.
  - IDLE with start_i & len_i=0: no stream traffic, stay in IDLE, done_o pulses on the next cycle.
  - RUN→DRAIN: in the cycle the element with cnt = len-1 is consumed.
  - DRAIN→IDLE: in the cycle the final d handshake completes (d.valid & d.ready). done_o pulses on the following cycle and busy_o drops in that same cycle.
  - start_i while busy is ignored.
- Input join:
  - fire = RUN & enable_i & s1_free & a.valid & b.valid & need_c_valid.
  - need_c is 1 in mode 0. In mode 1 it is 1 only when cnt = len-1; otherwise c is neither required nor consumed.
  - a.ready = b.ready = fire. c.ready = fire & need_c.
  - cnt_o increments on each fire.
- Stage 1 (product register):
  - On fire, latch p = signed(a)*signed(b) as 64 bits, latch c (or 0), and set a last flag; s1_valid is set.
  - s1_free = !s1_valid | s2_take.
- Stage 2:
  - s2_take = s1_valid & (!d.valid | d.ready) & enable_i.
  - Mode 0, on take: d.data = trunc32(p >>> shift) + c (32-bit wrap), d.valid=1.
  - Mode 1, on take of a non-last element: acc += p (64-bit wrap), no d output.
  - Mode 1, on take of the last element: d.data = trunc32((acc+p) >>> shift) + c, d.valid=1, acc cleared.
- Latency: a fire in cycle t gives d.valid in cycle t+2 when there is no backpressure. Throughput is 1 element/cycle.
- Output handshake: d.valid holds with d.data stable until d.ready. d.valid and d.data never depend combinationally on d.ready.
- enable_i low: no fire, no take; all registers hold, including the pending d.valid.
- clear_i mid-job: all state is dropped on the next edge and done_o is not pulsed. Elements held by the streamer FIFOs are the streamer's responsibility.
- shift=0: p is passed unshifted. Shift amounts up to 63 are legal, and the arithmetic shift keeps the sign.

Test Plan:
- Mode 0, len=3, shift=0, a={2,-3,7}, b={5,4,1}, c={1,1,1}, d.ready=1 → d={11,-11,8}; first d.valid 2 cycles after the first fire; done_o pulses once, the cycle after the third d handshake; cnt_o=3.
- Same stimulus, d.ready low for 5 cycles after the first d.valid → d.data holds at 11; a/b/c.ready drop once both stages are full; no element lost or duplicated; final d={11,-11,8}.
- Mode 1, len=4, shift=1, a={1,2,3,4}, b=all 1, c={5} → exactly one d = (10>>>1)+5 = 10; c.ready asserted only on the 4th fire.
- Mode 0, a=-7, b=1, c=0, shift=1 → d=-4 (arithmetic floor); a=32'h7FFFFFFF, b=2, shift=0, c=0 → d=32'hFFFFFFFE (truncation).
- start_i with len_i=0 → no ready asserted on any sink, done_o pulses on the next cycle, busy_o stays 0; a second start while busy is ignored (busy/cnt unaffected).
- clear_i asserted mid-job with d.valid=1 → next cycle d.valid=0, busy_o=0, cnt_o=0, no done_o; enable_i low for 3 cycles mid-job → state frozen, results match the uninterrupted run.
